// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types for the cache/memory arbiter: FSM state encoding, default
// line geometry and a default-sized cache line type.
package pipeline_types;

  typedef enum logic [2:0] {
    IDLE,
    IC_RD,
    DC_RD,
    DC_WR,
    RESP
  } arb_state_t;

  localparam int DEFAULT_LINE_WORDS = 4;
  localparam int DEFAULT_DATA_WIDTH = 32;

  typedef logic [DEFAULT_LINE_WORDS*DEFAULT_DATA_WIDTH-1:0] cache_line_t;

endpackage

// File: rtl/cache_mem_arbiter_rr_arbiter2.sv
// Two-requester round-robin picker; requester 0 is the icache, 1 the dcache.
// On a tie the side that did not win last time is granted.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  logic last_grant;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (req == 2'b11) grant = last_grant ? 2'b01 : 2'b10;
      else              grant = req;
    end
  end

  // Reset leaves the icache as last winner so the dcache takes the first tie.
  always_ff @(posedge clk) begin
    if (rst)                 last_grant <= 1'b0;
    else if (grant != 2'b00) last_grant <= grant[1];
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one word-serial memory port between icache refills and dcache
// refills/write-backs, sequencing each grant as a LINE_WORDS-word burst.
module cache_mem_arbiter
  import pipeline_types::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WORDS = DEFAULT_LINE_WORDS
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ic_rd_req,
  input  logic [ADDR_WIDTH-1:0]          ic_rd_addr,
  output logic                           ic_rd_valid,
  output logic [LINE_WORDS*DATA_WIDTH-1:0] ic_rd_data,
  input  logic                           dc_rd_req,
  input  logic [ADDR_WIDTH-1:0]          dc_rd_addr,
  output logic                           dc_rd_valid,
  output logic [LINE_WORDS*DATA_WIDTH-1:0] dc_rd_data,
  input  logic                           dc_wr_req,
  input  logic [ADDR_WIDTH-1:0]          dc_wr_addr,
  input  logic [LINE_WORDS*DATA_WIDTH-1:0] dc_wr_data,
  output logic                           dc_wr_done,
  input  logic                           branch_flush,
  output logic                           mem_req,
  output logic                           mem_we,
  output logic [ADDR_WIDTH-1:0]          mem_addr,
  output logic [DATA_WIDTH-1:0]          mem_wdata,
  input  logic                           mem_ack,
  input  logic [DATA_WIDTH-1:0]          mem_rdata
);

  localparam int LINE_BITS = LINE_WORDS * DATA_WIDTH;
  localparam int CNT_W     = $clog2(LINE_WORDS);
  localparam int WORD_SH   = $clog2(DATA_WIDTH / 8);
  localparam int OFF_W     = CNT_W + WORD_SH;
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(LINE_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((1 << OFF_W) - 1);

  arb_state_t             state, state_nxt, cur_op;
  logic [CNT_W-1:0]       cnt;
  logic [ADDR_WIDTH-1:0]  base;
  logic [ADDR_WIDTH-1:0]  grant_addr;
  logic [LINE_BITS-1:0]   line_buf;
  logic [LINE_BITS-1:0]   line_merged;
  logic                   drop;
  logic [1:0]             req_vec;
  logic [1:0]             grant;
  logic                   busy;
  logic                   last_ack;
  logic                   granting;

  // A flushed icache request is held off for this cycle only.
  assign req_vec  = {dc_wr_req | dc_rd_req, ic_rd_req & ~branch_flush};
  assign busy     = (state == IC_RD) || (state == DC_RD) || (state == DC_WR);
  assign last_ack = busy && mem_ack && (cnt == CNT_LAST);
  assign granting = (state == IDLE) && (grant != 2'b00);

  rr_arbiter2 u_rr (
    .clk   (clk),
    .rst   (rst),
    .en    (state == IDLE),
    .req   (req_vec),
    .grant (grant)
  );

  always_comb begin
    grant_addr = ic_rd_addr;
    if (grant[1]) grant_addr = dc_wr_req ? dc_wr_addr : dc_rd_addr;
  end

  always_comb begin
    line_merged = line_buf;
    line_merged[cnt*DATA_WIDTH +: DATA_WIDTH] = mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant[1])      state_nxt = dc_wr_req ? DC_WR : DC_RD;
        else if (grant[0]) state_nxt = IC_RD;
      end
      IC_RD, DC_RD, DC_WR: if (last_ack) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The write victim and the read line share one buffer; only one is live.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_op     <= IDLE;
      cnt        <= '0;
      base       <= '0;
      line_buf   <= '0;
      drop       <= 1'b0;
      ic_rd_data <= '0;
      dc_rd_data <= '0;
    end else begin
      if (granting) begin
        cur_op <= state_nxt;
        cnt    <= '0;
        drop   <= 1'b0;
        base   <= grant_addr & ~OFF_MASK;
        if (state_nxt == DC_WR) line_buf <= dc_wr_data;
      end else if (busy && mem_ack) begin
        if (!last_ack)        cnt <= cnt + CNT_W'(1);
        if (state != DC_WR)   line_buf <= line_merged;
        if (last_ack && state == DC_RD) dc_rd_data <= line_merged;
        if (last_ack && state == IC_RD && !drop && !branch_flush)
          ic_rd_data <= line_merged;
      end
      if (branch_flush && (state == IC_RD || (state == RESP && cur_op == IC_RD)))
        drop <= 1'b1;
    end
  end

  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    ic_rd_valid = 1'b0;
    dc_rd_valid = 1'b0;
    dc_wr_done  = 1'b0;
    case (state)
      IC_RD, DC_RD, DC_WR: begin
        mem_req   = 1'b1;
        mem_we    = (state == DC_WR);
        mem_addr  = base + (ADDR_WIDTH'(cnt) << WORD_SH);
        mem_wdata = line_buf[cnt*DATA_WIDTH +: DATA_WIDTH];
      end
      RESP: begin
        case (cur_op)
          IC_RD:   ic_rd_valid = !drop && !branch_flush;
          DC_RD:   dc_rd_valid = 1'b1;
          DC_WR:   dc_wr_done  = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed self-checking bench for cache_mem_arbiter: a per-cycle vector table
// for arbitration/refill timing plus hand-written multi-cycle corner cases.
module tb_cache_mem_arbiter;
  import pipeline_types::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 4;

  logic              clk;
  logic              rst;
  logic              ic_rd_req;
  logic [AW-1:0]     ic_rd_addr;
  logic              ic_rd_valid;
  cache_line_t       ic_rd_data;
  logic              dc_rd_req;
  logic [AW-1:0]     dc_rd_addr;
  logic              dc_rd_valid;
  cache_line_t       dc_rd_data;
  logic              dc_wr_req;
  logic [AW-1:0]     dc_wr_addr;
  cache_line_t       dc_wr_data;
  logic              dc_wr_done;
  logic              branch_flush;
  logic              mem_req;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic              mem_ack;
  logic [DW-1:0]     mem_rdata;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        ic;
    logic        dcr;
    logic        dcw;
    logic        fl;
    logic        ack;
    logic [31:0] rdata;
    logic        exp_req;
    logic        exp_we;
    logic [31:0] exp_addr;
    logic        exp_icv;
    logic        exp_dcv;
    logic        exp_done;
    int          chk;
    cache_line_t exp_line;
  } vec_t;

  vec_t vecs[$];

  logic wait_ack[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  int   wait_idx[7] = '{0, 1, 2, 2, 2, 2, 3};

  cache_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_WORDS(LW)) dut (
    .clk          (clk),
    .rst          (rst),
    .ic_rd_req    (ic_rd_req),
    .ic_rd_addr   (ic_rd_addr),
    .ic_rd_valid  (ic_rd_valid),
    .ic_rd_data   (ic_rd_data),
    .dc_rd_req    (dc_rd_req),
    .dc_rd_addr   (dc_rd_addr),
    .dc_rd_valid  (dc_rd_valid),
    .dc_rd_data   (dc_rd_data),
    .dc_wr_req    (dc_wr_req),
    .dc_wr_addr   (dc_wr_addr),
    .dc_wr_data   (dc_wr_data),
    .dc_wr_done   (dc_wr_done),
    .branch_flush (branch_flush),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic cache_line_t line4(input logic [31:0] w3, w2, w1, w0);
    return {w3, w2, w1, w0};
  endfunction

  function automatic vec_t mk(input logic ic, dcr, dcw, fl, ack, input logic [31:0] rd,
                              input logic er, ew, input logic [31:0] ea,
                              input logic eiv, edv, edd, input int chk, input cache_line_t el);
    vec_t v;
    v.ic = ic; v.dcr = dcr; v.dcw = dcw; v.fl = fl; v.ack = ack; v.rdata = rd;
    v.exp_req = er; v.exp_we = ew; v.exp_addr = ea;
    v.exp_icv = eiv; v.exp_dcv = edv; v.exp_done = edd;
    v.chk = chk; v.exp_line = el;
    return v;
  endfunction

  // One call is one clock cycle: inputs change 1 after the edge, outputs are read 2 after.
  task automatic applyStimulus(input logic ic, dcr, dcw, fl, ack, input logic [31:0] rd);
    @(posedge clk);
    #1;
    ic_rd_req    = ic;
    dc_rd_req    = dcr;
    dc_wr_req    = dcw;
    branch_flush = fl;
    mem_ack      = ack;
    mem_rdata    = rd;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  initial begin
    rst = 1'b1;
    ic_rd_req = 0; dc_rd_req = 0; dc_wr_req = 0; branch_flush = 0;
    mem_ack = 0; mem_rdata = '0;
    ic_rd_addr = 32'h1C00_0014; dc_rd_addr = 32'h2000_0040;
    dc_wr_addr = '0; dc_wr_data = '0;

    // Tie right after reset: dcache, then icache, then dcache again.
    vecs.push_back(mk(1,1,0,0,0,32'h0,   0,0,32'h0,          0,0,0, 0,'0));
    vecs.push_back(mk(1,1,0,0,1,32'hB0,  1,0,32'h2000_0040,  0,0,0, 0,'0));
    vecs.push_back(mk(1,1,0,0,1,32'hB1,  1,0,32'h2000_0044,  0,0,0, 0,'0));
    vecs.push_back(mk(1,1,0,0,1,32'hB2,  1,0,32'h2000_0048,  0,0,0, 0,'0));
    vecs.push_back(mk(1,1,0,0,1,32'hB3,  1,0,32'h2000_004C,  0,0,0, 0,'0));
    vecs.push_back(mk(1,1,0,0,0,32'h0,   0,0,32'h0,          0,1,0, 2,line4(32'hB3,32'hB2,32'hB1,32'hB0)));
    vecs.push_back(mk(1,1,0,0,0,32'h0,   0,0,32'h0,          0,0,0, 0,'0));
    vecs.push_back(mk(1,1,0,0,1,32'hC0,  1,0,32'h1C00_0010,  0,0,0, 0,'0));
    vecs.push_back(mk(1,1,0,0,1,32'hC1,  1,0,32'h1C00_0014,  0,0,0, 0,'0));
    vecs.push_back(mk(1,1,0,0,1,32'hC2,  1,0,32'h1C00_0018,  0,0,0, 0,'0));
    vecs.push_back(mk(1,1,0,0,1,32'hC3,  1,0,32'h1C00_001C,  0,0,0, 0,'0));
    vecs.push_back(mk(1,1,0,0,0,32'h0,   0,0,32'h0,          1,0,0, 1,line4(32'hC3,32'hC2,32'hC1,32'hC0)));
    vecs.push_back(mk(1,1,0,0,0,32'h0,   0,0,32'h0,          0,0,0, 0,'0));
    vecs.push_back(mk(1,1,0,0,1,32'hE0,  1,0,32'h2000_0040,  0,0,0, 0,'0));
    vecs.push_back(mk(1,1,0,0,1,32'hE1,  1,0,32'h2000_0044,  0,0,0, 0,'0));
    vecs.push_back(mk(1,1,0,0,1,32'hE2,  1,0,32'h2000_0048,  0,0,0, 0,'0));
    vecs.push_back(mk(1,1,0,0,1,32'hE3,  1,0,32'h2000_004C,  0,0,0, 0,'0));
    vecs.push_back(mk(1,1,0,0,0,32'h0,   0,0,32'h0,          0,1,0, 2,line4(32'hE3,32'hE2,32'hE1,32'hE0)));
    // Single icache refill at 0x1C00_0014: pulse five cycles after the request.
    vecs.push_back(mk(1,0,0,0,0,32'h0,   0,0,32'h0,          0,0,0, 0,'0));
    vecs.push_back(mk(1,0,0,0,1,32'hA0,  1,0,32'h1C00_0010,  0,0,0, 0,'0));
    vecs.push_back(mk(1,0,0,0,1,32'hA1,  1,0,32'h1C00_0014,  0,0,0, 0,'0));
    vecs.push_back(mk(1,0,0,0,1,32'hA2,  1,0,32'h1C00_0018,  0,0,0, 0,'0));
    vecs.push_back(mk(1,0,0,0,1,32'hA3,  1,0,32'h1C00_001C,  0,0,0, 0,'0));
    vecs.push_back(mk(1,0,0,0,0,32'h0,   0,0,32'h0,          1,0,0, 1,line4(32'hA3,32'hA2,32'hA1,32'hA0)));
    vecs.push_back(mk(0,0,0,0,0,32'h0,   0,0,32'h0,          0,0,0, 2,line4(32'hE3,32'hE2,32'hE1,32'hE0)));

    applyStimulus(0,0,0,0,0,'0);
    applyStimulus(0,0,0,0,0,'0);
    $display("[TB] checking reset state");
    checkOutput("reset mem_req",     mem_req,     0);
    checkOutput("reset mem_we",      mem_we,      0);
    checkOutput("reset mem_addr",    mem_addr,    0);
    checkOutput("reset mem_wdata",   mem_wdata,   0);
    checkOutput("reset ic_rd_valid", ic_rd_valid, 0);
    checkOutput("reset dc_rd_valid", dc_rd_valid, 0);
    checkOutput("reset dc_wr_done",  dc_wr_done,  0);
    checkOutput("reset ic_rd_data",  ic_rd_data,  0);
    checkOutput("reset dc_rd_data",  dc_rd_data,  0);
    rst = 1'b0;

    $display("[TB] running %0d table vectors", vecs.size());
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].ic, vecs[i].dcr, vecs[i].dcw, vecs[i].fl, vecs[i].ack, vecs[i].rdata);
      checkOutput($sformatf("vec%0d mem_req", i),     mem_req,     vecs[i].exp_req);
      checkOutput($sformatf("vec%0d ic_rd_valid", i), ic_rd_valid, vecs[i].exp_icv);
      checkOutput($sformatf("vec%0d dc_rd_valid", i), dc_rd_valid, vecs[i].exp_dcv);
      checkOutput($sformatf("vec%0d dc_wr_done", i),  dc_wr_done,  vecs[i].exp_done);
      if (vecs[i].exp_req) begin
        checkOutput($sformatf("vec%0d mem_we", i),   mem_we,   vecs[i].exp_we);
        checkOutput($sformatf("vec%0d mem_addr", i), mem_addr, vecs[i].exp_addr);
      end
      if (vecs[i].chk == 1) checkOutput($sformatf("vec%0d ic_rd_data", i), ic_rd_data, vecs[i].exp_line);
      if (vecs[i].chk == 2) checkOutput($sformatf("vec%0d dc_rd_data", i), dc_rd_data, vecs[i].exp_line);
    end

    $display("[TB] write-back before refill");
    dc_wr_addr = 32'h3000_0020; dc_rd_addr = 32'h3000_0080;
    dc_wr_data = line4(32'h44, 32'h33, 32'h22, 32'h11);
    applyStimulus(0,1,1,0,0,'0);
    checkOutput("wb grant mem_req", mem_req, 0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0,1,1,0,1,'0);
      checkOutput($sformatf("wb%0d mem_req", k),   mem_req,   1);
      checkOutput($sformatf("wb%0d mem_we", k),    mem_we,    1);
      checkOutput($sformatf("wb%0d mem_addr", k),  mem_addr,  32'h3000_0020 + 4*k);
      checkOutput($sformatf("wb%0d mem_wdata", k), mem_wdata, 32'h11 * (k + 1));
    end
    applyStimulus(0,1,1,0,0,'0);
    checkOutput("wb dc_wr_done",       dc_wr_done,  1);
    checkOutput("wb no dc_rd_valid",   dc_rd_valid, 0);
    checkOutput("wb resp mem_req",     mem_req,     0);
    applyStimulus(0,1,0,0,0,'0);
    checkOutput("wb refill grant mem_req", mem_req, 0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0,1,0,0,1,32'hF0 + k);
      checkOutput($sformatf("rf%0d mem_we", k),   mem_we,   0);
      checkOutput($sformatf("rf%0d mem_addr", k), mem_addr, 32'h3000_0080 + 4*k);
    end
    applyStimulus(0,1,0,0,0,'0);
    checkOutput("rf dc_rd_valid", dc_rd_valid, 1);
    checkOutput("rf dc_wr_done",  dc_wr_done,  0);
    checkOutput("rf dc_rd_data",  dc_rd_data,  line4(32'hF3, 32'hF2, 32'hF1, 32'hF0));
    applyStimulus(0,0,0,0,0,'0);

    $display("[TB] ack wait states on word 2");
    dc_wr_addr = 32'h4000_0000;
    dc_wr_data = line4(32'hD3, 32'hD2, 32'hD1, 32'hD0);
    applyStimulus(0,0,1,0,0,'0);
    checkOutput("ws grant mem_req", mem_req, 0);
    for (int k = 0; k < 7; k++) begin
      applyStimulus(0,0,1,0,wait_ack[k],'0);
      checkOutput($sformatf("ws%0d mem_req", k),    mem_req,    1);
      checkOutput($sformatf("ws%0d mem_addr", k),   mem_addr,   32'h4000_0000 + 4*wait_idx[k]);
      checkOutput($sformatf("ws%0d mem_wdata", k),  mem_wdata,  32'hD0 + wait_idx[k]);
      checkOutput($sformatf("ws%0d dc_wr_done", k), dc_wr_done, 0);
    end
    applyStimulus(0,0,1,0,0,'0);
    checkOutput("ws dc_wr_done", dc_wr_done, 1);
    checkOutput("ws resp mem_req", mem_req, 0);
    applyStimulus(0,0,0,0,0,'0);

    $display("[TB] branch flush during icache refill");
    ic_rd_addr = 32'h5000_0008; dc_rd_addr = 32'h5000_1000;
    applyStimulus(1,0,0,0,0,'0);
    checkOutput("fl grant mem_req", mem_req, 0);
    applyStimulus(1,1,0,0,1,32'h1);
    checkOutput("fl w0 mem_addr", mem_addr, 32'h5000_0000);
    applyStimulus(1,1,0,1,1,32'h2);
    checkOutput("fl w1 mem_req",  mem_req,  1);
    checkOutput("fl w1 mem_addr", mem_addr, 32'h5000_0004);
    applyStimulus(0,1,0,0,1,32'h3);
    checkOutput("fl w2 mem_req",  mem_req,  1);
    checkOutput("fl w2 mem_addr", mem_addr, 32'h5000_0008);
    applyStimulus(0,1,0,0,1,32'h4);
    checkOutput("fl w3 mem_req",  mem_req,  1);
    checkOutput("fl w3 mem_addr", mem_addr, 32'h5000_000C);
    applyStimulus(0,1,0,0,0,'0);
    checkOutput("fl no ic_rd_valid", ic_rd_valid, 0);
    checkOutput("fl resp mem_req",   mem_req,     0);
    applyStimulus(0,1,0,0,0,'0);
    checkOutput("fl dc grant mem_req", mem_req, 0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0,1,0,0,1,32'h70 + k);
      checkOutput($sformatf("fl dc%0d mem_req", k),  mem_req,  1);
      checkOutput($sformatf("fl dc%0d mem_addr", k), mem_addr, 32'h5000_1000 + 4*k);
    end
    applyStimulus(0,1,0,0,0,'0);
    checkOutput("fl dc_rd_valid",     dc_rd_valid, 1);
    checkOutput("fl still no ic_rd_valid", ic_rd_valid, 0);
    applyStimulus(0,0,0,0,0,'0);

    $display("[TB] reset during write-back");
    dc_wr_addr = 32'h6000_0040; dc_rd_addr = 32'h6000_0100;
    dc_wr_data = line4(32'h9, 32'h8, 32'h7, 32'h6);
    applyStimulus(0,0,1,0,0,'0);
    applyStimulus(0,0,1,0,1,'0);
    checkOutput("rs w0 mem_we", mem_we, 1);
    applyStimulus(0,0,1,0,1,'0);
    applyStimulus(0,0,1,0,0,'0);
    checkOutput("rs w2 mem_addr", mem_addr, 32'h6000_0048);
    rst = 1'b1;
    applyStimulus(0,0,0,0,0,'0);
    rst = 1'b0;
    checkOutput("rs mem_req",    mem_req,    0);
    checkOutput("rs dc_wr_done", dc_wr_done, 0);
    checkOutput("rs dc_rd_data", dc_rd_data, 0);
    applyStimulus(1,1,0,0,0,'0);
    checkOutput("rs idle mem_req",    mem_req,    0);
    checkOutput("rs idle dc_wr_done", dc_wr_done, 0);
    applyStimulus(1,1,0,0,1,32'h5);
    checkOutput("rs tie mem_req",  mem_req,  1);
    checkOutput("rs tie mem_we",   mem_we,   0);
    checkOutput("rs tie mem_addr", mem_addr, 32'h6000_0100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
